nids_pkt_merger: RTL and testbench
==================================

Name: nids_pkt_merger

Overview:
- Two-input, one-output packet merger that recombines the streams returned by the two parallel inspection engines into a single output stream.
- Arbitration is packet-atomic: once an input is granted, the whole packet passes before the grant can change. Inputs are served round-robin.
- Framing follows the ingress splitter: one or more header words (ctrl!=0), then one or more payload words (ctrl==0), then a closing word (ctrl!=0).
- Output is registered. The block also keeps per-input packet counters and a sticky stall flag.

Parameters:
- DATA_W, 64, data word width.
- CTRL_W, 8, control word width.
- CNT_W, 16, width of each per-input packet counter.
- STALL_LIMIT, 1024, number of consecutive starved cycles mid-packet before stall_err sets (must be >=2).

Ports:
- clk  in  1  clock.
- reset  in  1  reset: asynchronous, active-high.
- in_req0  in  1  input 0 has at least one full packet queued.
- in_wr0  in  1  input 0 word valid; legal only while in_rdy0=1.
- in_ctrl0  in  CTRL_W  input 0 control word.
- in_data0  in  DATA_W  input 0 data word.
- in_rdy0  out  1  input 0 may write this cycle.
- in_req1, in_wr1, in_ctrl1, in_data1, in_rdy1: same as input 0, for input 1.
- out_wr  out  1  output word valid (registered).
- out_ctrl  out  CTRL_W  output control word (registered).
- out_data  out  DATA_W  output data word (registered).
- out_rdy  in  1  downstream can absorb at least 2 more words.
- grant  out  1  index of the currently or last granted input.
- busy  out  1  a packet is in flight (state != IDLE).
- pkt_cnt0  out  CNT_W  packets completed from input 0.
- pkt_cnt1  out  CNT_W  packets completed from input 1.
- stall_err  out  1  sticky: the granted input starved mid-packet.

Behaviour:
- Reset values (async, active-high, applies mid-packet too):
  - State IDLE, grant=0, round-robin pointer rr=0.
  - out_wr=0, out_ctrl=0, out_data=0.
  - pkt_cnt0=0, pkt_cnt1=0, stall_err=0, stall counter=0.
  - A partial packet in progress is discarded; no recovery is attempted.
- Registered state machine with states IDLE, HDR, PAYLOAD.
- IDLE:
  - in_rdy0=in_rdy1=0.
  - If in_req[rr]=1: grant<=rr, go to HDR.
  - Else if in_req[~rr]=1: grant<=~rr, go to HDR.
  - Else stay in IDLE.
  - Every packet therefore costs one bubble cycle.
- Ready generation (combinational):
  - in_rdy[grant] = out_rdy while in HDR or PAYLOAD.
  - The non-granted in_rdy is always 0.
- Acceptance: acc = in_wr[grant] & in_rdy[grant].
- HDR:
  - acc with ctrl!=0: stay in HDR.
  - acc with ctrl==0: go to PAYLOAD.
- PAYLOAD:
  - acc with ctrl==0: stay in PAYLOAD.
  - acc with ctrl!=0: closing word.
    - Go to IDLE and set rr <= ~grant.
    - Increment pkt_cnt[grant]; the counter wraps from 2^CNT_W-1 to 0.
- Datapath latency is exactly 1 cycle:
  - On acc: next cycle out_wr=1, out_ctrl/out_data = the accepted word.
  - Otherwise out_wr=0 next cycle; out_ctrl/out_data hold their last value.
- out_rdy dropping:
  - Takes effect on in_rdy in the same cycle.
  - The word already in the output register is still presented; downstream's 2-word headroom absorbs it.
- Protocol violations:
  - in_wr on a non-granted input, or while in IDLE: the word is ignored (not forwarded, no state change).
  - The non-granted input is never accepted, even if it asserts in_wr.
- Stall monitor:
  - In HDR/PAYLOAD, count cycles where out_rdy=1 and in_wr[grant]=0.
  - The count resets to 0 on any acc and on entry to IDLE.
  - When the count reaches STALL_LIMIT, stall_err<=1.
  - stall_err is cleared only by reset. The lock is never broken; the packet completes normally when the input resumes.
- Outputs:
  - busy = (state != IDLE).
  - grant holds its value through IDLE.
- Simultaneous in_req0 and in_req1 in IDLE: input rr wins, so under continuous requests the grant alternates 0,1,0,1 on packet boundaries.

Test Plan:
- Single input: in_req0=1, packet of 2 hdr + 3 payload + closing word (ctrl 0xFF,0x01,0,0,0,0x10), out_rdy=1 -> the same 6 words appear on out_* each 1 cycle after acceptance; pkt_cnt0=1; grant=0; busy=0 afterwards.
- Fairness: in_req0=in_req1=1 continuously, 4 packets queued per input -> output packet order 0,1,0,1,...; pkt_cnt0=pkt_cnt1=4; no interleaving of words from different inputs within a packet.
- Backpressure: drop out_rdy for 5 cycles mid-payload -> in_rdy[grant]=0 in the same cycles; no words lost or duplicated; at most 1 out_wr after out_rdy falls.
- Stall: STALL_LIMIT=8; granted input stops in PAYLOAD with out_rdy=1 -> stall_err=1 after 8 idle cycles; on resume, the packet completes intact and stall_err stays 1.
- Reset mid-packet: assert reset during PAYLOAD of input 1 -> out_wr=0, counters=0, state IDLE, grant=0 immediately; the next packet from input 0 passes cleanly.
- Violations and wrap: in_wr1 pulsed while input 0 is granted -> nothing forwarded from input 1. CNT_W=2 with 5 packets on input 0 -> pkt_cnt0=1.

Source files
------------

// File: rtl/nids_pkt_merger.sv
`default_nettype none
// ============================================================================
// Module   : nids_pkt_merger
// Purpose  : Two-input, one-output packet merger. Recombines the streams
//            returned by the two parallel inspection engines into a single
//            registered output stream. Arbitration is packet-atomic and
//            round-robin. Per-input packet counters and a sticky stall flag
//            are kept for monitoring.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_W       data word width
//   CTRL_W       control word width
//   CNT_W        width of each per-input packet counter
//   STALL_LIMIT  starved mid-packet cycles before stall_err sets (>= 2)
// Ports
//   clk, reset             clock / asynchronous active-high reset
//   in_req0/1              input has at least one full packet queued
//   in_wr0/1               input word valid (honoured only with in_rdy)
//   in_ctrl0/1, in_data0/1 input control / data words
//   in_rdy0/1              input may write this cycle
//   out_wr                 output word valid (registered)
//   out_ctrl, out_data     output control / data words (registered)
//   out_rdy                downstream can absorb at least 2 more words
//   grant                  index of the current or last granted input
//   busy                   a packet is in flight
//   pkt_cnt0/1             packets completed per input (wrapping)
//   stall_err              sticky: granted input starved mid-packet
// ----------------------------------------------------------------------------
// Framing: one or more header words (ctrl != 0), one or more payload words
// (ctrl == 0), then a closing word (ctrl != 0). The closing word is detected
// as the first non-zero ctrl accepted while in PAYLOAD.
// ============================================================================
module nids_pkt_merger #(
  parameter int DATA_W      = 64,
  parameter int CTRL_W      = 8,
  parameter int CNT_W       = 16,
  parameter int STALL_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              in_req0,
  input  logic              in_wr0,
  input  logic [CTRL_W-1:0] in_ctrl0,
  input  logic [DATA_W-1:0] in_data0,
  output logic              in_rdy0,

  input  logic              in_req1,
  input  logic              in_wr1,
  input  logic [CTRL_W-1:0] in_ctrl1,
  input  logic [DATA_W-1:0] in_data1,
  output logic              in_rdy1,

  output logic              out_wr,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_rdy,

  output logic              grant,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1,
  output logic              stall_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  // Stall counter is wide enough to hold STALL_LIMIT itself so it can
  // saturate there instead of wrapping back into the "healthy" range.
  localparam int              SC_W         = $clog2(STALL_LIMIT + 1);
  localparam logic [SC_W-1:0] c_stall_last = SC_W'(STALL_LIMIT - 1);
  localparam logic [SC_W-1:0] c_stall_max  = SC_W'(STALL_LIMIT);
  localparam logic [SC_W-1:0] c_stall_one  = SC_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t            r_state;
  logic              r_grant;
  logic              r_rr;
  logic [SC_W-1:0]   r_stall_cnt;
  logic              r_stall_err;
  logic              r_out_wr;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic [DATA_W-1:0] r_out_data;
  logic [CNT_W-1:0]  r_pkt_cnt0;
  logic [CNT_W-1:0]  r_pkt_cnt1;

  // --------------------------------------------------------------------------
  // Combinational selection of the granted input
  // --------------------------------------------------------------------------
  logic [1:0]        w_req;
  logic [1:0]        w_wr;
  logic              w_active;
  logic              w_sel_wr;
  logic [CTRL_W-1:0] w_sel_ctrl;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_acc;
  logic              w_ctrl_nz;
  logic              w_close;
  logic              w_starved;

  assign w_req    = {in_req1, in_req0};
  assign w_wr     = {in_wr1, in_wr0};
  assign w_active = (r_state != IDLE);

  // Only the granted input ever sees ready; it follows out_rdy in the same
  // cycle so a downstream drop stops intake immediately.
  assign in_rdy0 = w_active & out_rdy & ~r_grant;
  assign in_rdy1 = w_active & out_rdy &  r_grant;

  assign w_sel_wr   = w_wr[r_grant];
  assign w_sel_ctrl = r_grant ? in_ctrl1 : in_ctrl0;
  assign w_sel_data = r_grant ? in_data1 : in_data0;

  // Words from the non-granted input, or while IDLE, never reach w_acc.
  assign w_acc     = w_active & out_rdy & w_sel_wr;
  assign w_ctrl_nz = |w_sel_ctrl;
  assign w_close   = w_acc & w_ctrl_nz & (r_state == PAYLOAD);
  assign w_starved = w_active & out_rdy & ~w_sel_wr;

  // --------------------------------------------------------------------------
  // Arbitration / framing state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= 1'b0;
      r_rr    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // Preferred input first, then the other; grant is held otherwise.
          if (w_req[r_rr]) begin
            r_grant <= r_rr;
            r_state <= HDR;
          end else if (w_req[~r_rr]) begin
            r_grant <= ~r_rr;
            r_state <= HDR;
          end
        end
        HDR: begin
          if (w_acc && !w_ctrl_nz) begin
            r_state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (w_close) begin
            r_state <= IDLE;
            r_rr    <= ~r_grant;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output register: one-cycle latency; ctrl/data hold when nothing accepted
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_wr   <= 1'b0;
      r_out_ctrl <= '0;
      r_out_data <= '0;
    end else begin
      r_out_wr <= w_acc;
      if (w_acc) begin
        r_out_ctrl <= w_sel_ctrl;
        r_out_data <= w_sel_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-input packet counters (wrap naturally)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pkt_cnt0 <= '0;
    end else if (w_close && !r_grant) begin
      r_pkt_cnt0 <= r_pkt_cnt0 + c_cnt_one;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pkt_cnt1 <= '0;
    end else if (w_close && r_grant) begin
      r_pkt_cnt1 <= r_pkt_cnt1 + c_cnt_one;
    end
  end

  // --------------------------------------------------------------------------
  // Stall monitor. Cycles with out_rdy low are downstream's fault and are not
  // counted. The flag is set on the same edge the count reaches the limit;
  // the lock is never broken, the packet simply resumes later.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
    end else if (!w_active || w_acc) begin
      r_stall_cnt <= '0;
    end else if (w_starved && (r_stall_cnt != c_stall_max)) begin
      r_stall_cnt <= r_stall_cnt + c_stall_one;
      if (r_stall_cnt == c_stall_last) begin
        r_stall_err <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output assignments
  // --------------------------------------------------------------------------
  assign out_wr    = r_out_wr;
  assign out_ctrl  = r_out_ctrl;
  assign out_data  = r_out_data;
  assign grant     = r_grant;
  assign busy      = w_active;
  assign pkt_cnt0  = r_pkt_cnt0;
  assign pkt_cnt1  = r_pkt_cnt1;
  assign stall_err = r_stall_err;

endmodule
`default_nettype wire

// File: tb/tb_nids_pkt_merger.sv
`default_nettype none
// ============================================================================
// Module   : tb_nids_pkt_merger
// Purpose  : Directed self-checking bench for nids_pkt_merger. Words are
//            pushed into an expected queue as they are driven; a monitor on
//            the falling edge matches every out_wr word, including its
//            one-cycle latency. Run with STALL_LIMIT=8, CNT_W=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nids_pkt_merger;

  localparam int DATA_W      = 64;
  localparam int CTRL_W      = 8;
  localparam int CNT_W       = 3;
  localparam int STALL_LIMIT = 8;
  localparam int WAIT_MAX    = 40;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_req0, in_wr0, in_rdy0;
  logic [CTRL_W-1:0] in_ctrl0;
  logic [DATA_W-1:0] in_data0;
  logic              in_req1, in_wr1, in_rdy1;
  logic [CTRL_W-1:0] in_ctrl1;
  logic [DATA_W-1:0] in_data1;
  logic              out_wr;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic              out_rdy;
  logic              grant, busy, stall_err;
  logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int bp_wr_cnt;

  logic [CTRL_W-1:0] exp_ctrl_q[$];
  logic [DATA_W-1:0] exp_data_q[$];
  int                exp_cyc_q[$];
  logic [CNT_W-1:0]  exp_cnt0, exp_cnt1;
  logic              exp_rr;

  nids_pkt_merger #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .in_req0(in_req0), .in_wr0(in_wr0), .in_ctrl0(in_ctrl0), .in_data0(in_data0), .in_rdy0(in_rdy0),
    .in_req1(in_req1), .in_wr1(in_wr1), .in_ctrl1(in_ctrl1), .in_data1(in_data1), .in_rdy1(in_rdy1),
    .out_wr(out_wr), .out_ctrl(out_ctrl), .out_data(out_data), .out_rdy(out_rdy),
    .grant(grant), .busy(busy), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .stall_err(stall_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check1(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every registered output word must match the queue head
  // and appear exactly one cycle after the edge that accepted it.
  always @(negedge clk) begin
    if (out_wr === 1'b1) begin
      check1("out_word_expected", 64'(exp_ctrl_q.size() != 0), 64'd1);
      if (exp_ctrl_q.size() != 0) begin
        check1("out_ctrl", 64'(out_ctrl), 64'(exp_ctrl_q[0]));
        check1("out_data", out_data, exp_data_q[0]);
        check1("out_latency", 64'(cyc), 64'(exp_cyc_q[0]));
        void'(exp_ctrl_q.pop_front());
        void'(exp_data_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end
  end

  function automatic logic rdy_of(input int port);
    return (port == 0) ? in_rdy0 : in_rdy1;
  endfunction

  task automatic set_in(input int port, input logic wr, input logic [7:0] c, input logic [63:0] d);
    if (port == 0) begin
      in_wr0 = wr; in_ctrl0 = c; in_data0 = d;
    end else begin
      in_wr1 = wr; in_ctrl1 = c; in_data1 = d;
    end
  endtask

  // Wait (bounded) for ready on the port, then present one word for one cycle.
  task automatic drive_word(input int port, input logic [7:0] c, input logic [63:0] d);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (rdy_of(port) !== 1'b1 && n < WAIT_MAX) begin
      set_in(port, 1'b0, c, d);
      n++;
      @(negedge clk); #1;
    end
    check1("rdy_within_budget", 64'(n < WAIT_MAX), 64'd1);
    if (n < WAIT_MAX) begin
      set_in(port, 1'b1, c, d);
      exp_ctrl_q.push_back(c);
      exp_data_q.push_back(d);
      exp_cyc_q.push_back(cyc + 1);
    end
  endtask

  task automatic release_port(input int port);
    @(negedge clk); #1;
    set_in(port, 1'b0, 8'h00, 64'h0);
  endtask

  // Full packet: n_hdr headers (FF,01,02..), n_pay zero-ctrl words, close 0x10.
  task automatic send_pkt(input int port, input int n_hdr, input int n_pay, input logic [15:0] tag);
    int idx;
    idx = 0;
    for (int i = 0; i < n_hdr; i++) begin
      drive_word(port, (i == 0) ? 8'hFF : 8'(i), {8'(port), 8'h00, tag, 32'(idx)});
      idx++;
      if (i == 0) check1("grant_at_pkt_start", 64'(grant), 64'(port));
    end
    for (int i = 0; i < n_pay; i++) begin
      drive_word(port, 8'h00, {8'(port), 8'h00, tag, 32'(idx)});
      idx++;
    end
    drive_word(port, 8'h10, {8'(port), 8'h00, tag, 32'(idx)});
    release_port(port);
    if (port == 0) exp_cnt0 = exp_cnt0 + 3'd1;
    else           exp_cnt1 = exp_cnt1 + 3'd1;
    exp_rr = (port == 0);
    check1("busy_after_close", 64'(busy), 64'd0);
    check1("pkt_cnt0", 64'(pkt_cnt0), 64'(exp_cnt0));
    check1("pkt_cnt1", 64'(pkt_cnt1), 64'(exp_cnt1));
  endtask

  initial begin
    reset = 1'b1; out_rdy = 1'b1;
    in_req0 = 1'b0; in_req1 = 1'b0;
    set_in(0, 1'b0, 8'h00, 64'h0);
    set_in(1, 1'b0, 8'h00, 64'h0);
    exp_cnt0 = '0; exp_cnt1 = '0; exp_rr = 1'b0;

    // ---- reset state
    repeat (3) @(negedge clk);
    check1("rst_out_wr",    64'(out_wr),    64'd0);
    check1("rst_out_ctrl",  64'(out_ctrl),  64'd0);
    check1("rst_out_data",  out_data,       64'd0);
    check1("rst_grant",     64'(grant),     64'd0);
    check1("rst_busy",      64'(busy),      64'd0);
    check1("rst_pkt_cnt0",  64'(pkt_cnt0),  64'd0);
    check1("rst_pkt_cnt1",  64'(pkt_cnt1),  64'd0);
    check1("rst_stall_err", 64'(stall_err), 64'd0);
    check1("rst_in_rdy0",   64'(in_rdy0),   64'd0);
    check1("rst_in_rdy1",   64'(in_rdy1),   64'd0);
    #1 reset = 1'b0;

    // ---- single packet on input 0: FF,01,00,00,00,10
    in_req0 = 1'b1;
    send_pkt(0, 2, 3, 16'h0001);
    in_req0 = 1'b0;
    check1("single_grant", 64'(grant), 64'd0);
    check1("single_cnt0",  64'(pkt_cnt0), 64'd1);
    @(negedge clk); #1;
    check1("single_idle_busy", 64'(busy), 64'd0);

    // ---- fairness: both inputs request continuously, 4 packets each
    in_req0 = 1'b1; in_req1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      send_pkt(exp_rr ? 1 : 0, 1, 2, 16'h0100 + 16'(k));
    end
    in_req0 = 1'b0; in_req1 = 1'b0;
    check1("fair_cnt0", 64'(pkt_cnt0), 64'd5);
    check1("fair_cnt1", 64'(pkt_cnt1), 64'd4);

    // ---- backpressure: out_rdy low for 5 cycles mid-payload
    in_req0 = 1'b1;
    fork
      send_pkt(0, 1, 6, 16'h0200);
      begin
        repeat (4) @(negedge clk);
        out_rdy = 1'b0;
        bp_wr_cnt = 0;
        repeat (5) begin
          #2;
          check1("bp_in_rdy0_low", 64'(in_rdy0), 64'd0);
          check1("bp_in_rdy1_low", 64'(in_rdy1), 64'd0);
          check1("bp_busy",        64'(busy),    64'd1);
          if (out_wr === 1'b1) bp_wr_cnt++;
          @(negedge clk);
        end
        out_rdy = 1'b1;
      end
    join
    in_req0 = 1'b0;
    check1("bp_out_wr_at_most_1", 64'(bp_wr_cnt <= 1), 64'd1);
    check1("bp_no_stall", 64'(stall_err), 64'd0);

    // ---- stall: input 1 goes quiet in PAYLOAD with out_rdy high
    in_req1 = 1'b1;
    drive_word(1, 8'hFF, 64'h0100_0300_0000_0000);
    check1("stall_grant", 64'(grant), 64'd1);
    drive_word(1, 8'h00, 64'h0100_0300_0000_0001);
    repeat (8) begin
      @(negedge clk); #1;
      set_in(1, 1'b0, 8'h00, 64'h0);
    end
    check1("stall_err_before_limit", 64'(stall_err), 64'd0);
    repeat (2) begin
      @(negedge clk); #1;
      set_in(1, 1'b0, 8'h00, 64'h0);
    end
    check1("stall_err_set", 64'(stall_err), 64'd1);
    check1("stall_still_busy", 64'(busy), 64'd1);
    drive_word(1, 8'h00, 64'h0100_0300_0000_0002);
    drive_word(1, 8'h10, 64'h0100_0300_0000_0003);
    release_port(1);
    in_req1 = 1'b0;
    exp_cnt1 = exp_cnt1 + 3'd1; exp_rr = 1'b0;
    check1("stall_cnt1", 64'(pkt_cnt1), 64'(exp_cnt1));
    check1("stall_err_sticky", 64'(stall_err), 64'd1);

    // ---- violations: write while IDLE, write on the non-granted input
    repeat (3) begin
      @(negedge clk); #1;
      set_in(0, 1'b1, 8'hAA, 64'hDEAD_0000_0000_0001);
      check1("idle_wr_busy", 64'(busy), 64'd0);
    end
    @(negedge clk); #1;
    set_in(0, 1'b0, 8'h00, 64'h0);
    in_req0 = 1'b1;
    fork
      send_pkt(0, 1, 2, 16'h0400);
      begin
        repeat (2) @(negedge clk);
        #2 set_in(1, 1'b1, 8'h55, 64'hBAD0_0000_0000_0001);
        check1("viol_in_rdy1", 64'(in_rdy1), 64'd0);
        @(negedge clk);
        #2 check1("viol_in_rdy1_b", 64'(in_rdy1), 64'd0);
        check1("viol_grant", 64'(grant), 64'd0);
        set_in(1, 1'b0, 8'h00, 64'h0);
      end
    join
    in_req0 = 1'b0;

    // ---- asynchronous reset during PAYLOAD of input 1
    in_req1 = 1'b1;
    drive_word(1, 8'hFF, 64'h0100_0500_0000_0000);
    drive_word(1, 8'h00, 64'h0100_0500_0000_0001);
    drive_word(1, 8'h00, 64'h0100_0500_0000_0002);
    @(negedge clk); #1;
    set_in(1, 1'b0, 8'h00, 64'h0);
    in_req1 = 1'b0;
    check1("pre_rst_busy",  64'(busy),  64'd1);
    check1("pre_rst_grant", 64'(grant), 64'd1);
    #2 reset = 1'b1;
    #1;
    check1("mid_rst_out_wr",   64'(out_wr),    64'd0);
    check1("mid_rst_out_data", out_data,       64'd0);
    check1("mid_rst_busy",     64'(busy),      64'd0);
    check1("mid_rst_grant",    64'(grant),     64'd0);
    check1("mid_rst_cnt0",     64'(pkt_cnt0),  64'd0);
    check1("mid_rst_cnt1",     64'(pkt_cnt1),  64'd0);
    check1("mid_rst_stall",    64'(stall_err), 64'd0);
    check1("mid_rst_queue",    64'(exp_ctrl_q.size()), 64'd0);
    exp_cnt0 = '0; exp_cnt1 = '0; exp_rr = 1'b0;
    @(negedge clk); #1 reset = 1'b0;

    // ---- clean packets on input 0 after reset, counter wraps at 8
    in_req0 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      send_pkt(0, 1, 1, 16'h0600 + 16'(k));
    end
    in_req0 = 1'b0;
    check1("wrap_cnt0", 64'(pkt_cnt0), 64'd1);
    check1("wrap_cnt1", 64'(pkt_cnt1), 64'd0);

    repeat (3) @(negedge clk);
    check1("final_queue_empty", 64'(exp_ctrl_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
